// File: rtl/dmem_sram_ctrl_pkg.sv
// Shared memory-op codes and access-size decoding for the data-memory SRAM controller.
package dmem_sram_ctrl_pkg;

  localparam logic [6:0] MEM_OP_NULL   = 7'd0;
  localparam logic [6:0] MEM_OP_WORD   = 7'd1;
  localparam logic [6:0] MEM_OP_HWORD  = 7'd2;
  localparam logic [6:0] MEM_OP_HWORDU = 7'd3;
  localparam logic [6:0] MEM_OP_BYTE   = 7'd4;
  localparam logic [6:0] MEM_OP_BYTEU  = 7'd5;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } acc_size_e;

  // Unknown codes fall back to a full-word access.
  function automatic acc_size_e op_size(input logic [6:0] op);
    case (op)
      MEM_OP_HWORD, MEM_OP_HWORDU: op_size = SZ_HALF;
      MEM_OP_BYTE, MEM_OP_BYTEU:   op_size = SZ_BYTE;
      default:                     op_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_ctrl_if.sv
// MEM-stage side of the data-memory controller: request controls in, raw load word and stall out.
interface dmem_sram_ctrl_if;
  logic [31:0] mem_addr;
  logic        mem_op;
  logic        mem_wr;
  logic [6:0]  mem_op_type;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        stall;

  modport master (
    output mem_addr, mem_op, mem_wr, mem_op_type, st_data,
    input  ld_data, stall
  );

  modport slave (
    input  mem_addr, mem_op, mem_wr, mem_op_type, st_data,
    output ld_data, stall
  );
endinterface

// File: rtl/dmem_st_align.sv
// Store alignment: replicates store data across lanes and selects active-low byte enables.
module dmem_st_align
  import dmem_sram_ctrl_pkg::*;
(
  input  logic [31:0] st_data,
  input  logic [1:0]  addr_lo,
  input  logic [6:0]  op_type,
  output logic [31:0] dq,
  output logic [3:0]  be_n
);

  always_comb begin
    dq   = st_data;
    be_n = '0;
    case (op_size(op_type))
      SZ_HALF: begin
        dq   = {2{st_data[15:0]}};
        be_n = addr_lo[1] ? 4'b0011 : 4'b1100;
      end
      SZ_BYTE: begin
        dq   = {4{st_data[7:0]}};
        be_n = '1;
        be_n[addr_lo] = 1'b0;
      end
      default: begin
        dq   = st_data;
        be_n = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_sram_ctrl.sv
// Multi-cycle asynchronous-SRAM access controller; stalls the pipeline until each access completes.
module dmem_sram_ctrl
  import dmem_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_sram_ctrl_if.slave   mem,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_t,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int RD_N = (RD_WAIT < 1) ? 1 : RD_WAIT;
  localparam int WR_N = (WR_WAIT < 1) ? 1 : WR_WAIT;
  localparam logic [15:0] RD_LOAD = 16'(RD_N - 1);
  localparam logic [15:0] WR_LOAD = 16'(WR_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_e;

  state_e              state, state_nx;
  logic [15:0]         cnt, cnt_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [31:0]         dq_o_nx, ld_q, ld_nx;
  logic                dq_t_nx, ce_nx, oe_nx, we_nx;
  logic [3:0]          be_nx;
  logic [31:0]         align_dq;
  logic [3:0]          align_be;

  dmem_st_align u_align (
    .st_data (mem.st_data),
    .addr_lo (mem.mem_addr[1:0]),
    .op_type (mem.mem_op_type),
    .dq      (align_dq),
    .be_n    (align_be)
  );

  generate
    if (ADDR_W < 30) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem.mem_addr[31:ADDR_W+2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sram_addr <= '0;
      sram_dq_o <= '0;
      sram_dq_t <= 1'b1;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      ld_q      <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sram_addr <= addr_nx;
      sram_dq_o <= dq_o_nx;
      sram_dq_t <= dq_t_nx;
      sram_ce_n <= ce_nx;
      sram_oe_n <= oe_nx;
      sram_we_n <= we_nx;
      sram_be_n <= be_nx;
      ld_q      <= ld_nx;
    end
  end

  // Next-state logic also computes the next value of every registered SRAM pin.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = sram_addr;
    dq_o_nx  = sram_dq_o;
    dq_t_nx  = sram_dq_t;
    ce_nx    = sram_ce_n;
    oe_nx    = sram_oe_n;
    we_nx    = sram_we_n;
    be_nx    = sram_be_n;
    ld_nx    = ld_q;
    case (state)
      S_IDLE: begin
        if (mem.mem_op) begin
          addr_nx = mem.mem_addr[ADDR_W+1:2];
          ce_nx   = 1'b0;
          if (!mem.mem_wr) begin
            oe_nx    = 1'b0;
            be_nx    = '0;
            cnt_nx   = RD_LOAD;
            state_nx = S_RD;
          end else begin
            dq_o_nx  = align_dq;
            be_nx    = align_be;
            dq_t_nx  = 1'b0;
            we_nx    = 1'b1;
            state_nx = S_WR_SETUP;
          end
        end
      end
      S_RD: begin
        if (cnt == '0) begin
          ld_nx    = sram_dq_i;
          ce_nx    = 1'b1;
          oe_nx    = 1'b1;
          be_nx    = '1;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      S_WR_SETUP: begin
        we_nx    = 1'b0;
        cnt_nx   = WR_LOAD;
        state_nx = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt == '0) begin
          we_nx    = 1'b1;
          state_nx = S_WR_HOLD;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      S_WR_HOLD: begin
        ce_nx    = 1'b1;
        dq_t_nx  = 1'b1;
        be_nx    = '1;
        state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign mem.ld_data = ld_q;
  assign mem.stall   = !rst && (((state == S_IDLE) && mem.mem_op) ||
                                ((state != S_IDLE) && (state != S_DONE)));

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl: two instances (RD_WAIT=1 and RD_WAIT=3) each on a byte-lane SRAM model.
module tb_dmem_sram_ctrl;
  import dmem_sram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_op = 1'b0;
  logic        mem_wr = 1'b0;
  logic [6:0]  mem_op_type = MEM_OP_NULL;
  logic [31:0] st_data = '0;
  int          sel = 0;

  logic [17:0] s_addr [2];
  logic [31:0] s_dq_i [2];
  logic [31:0] s_dq_o [2];
  logic        s_t    [2];
  logic        s_ce   [2];
  logic        s_oe   [2];
  logic        s_we   [2];
  logic [3:0]  s_be   [2];
  logic        s_stall[2];
  logic [31:0] s_ld   [2];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gd
      dmem_sram_ctrl_if bus ();
      logic [31:0] sram [256];

      assign bus.mem_addr    = mem_addr;
      assign bus.mem_op      = mem_op && (sel == g);
      assign bus.mem_wr      = mem_wr;
      assign bus.mem_op_type = mem_op_type;
      assign bus.st_data     = st_data;
      assign s_stall[g]      = bus.stall;
      assign s_ld[g]         = bus.ld_data;

      dmem_sram_ctrl #(.ADDR_W(18), .RD_WAIT((g == 0) ? 1 : 3), .WR_WAIT(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (bus),
        .sram_addr (s_addr[g]),
        .sram_dq_i (s_dq_i[g]),
        .sram_dq_o (s_dq_o[g]),
        .sram_dq_t (s_t[g]),
        .sram_ce_n (s_ce[g]),
        .sram_oe_n (s_oe[g]),
        .sram_we_n (s_we[g]),
        .sram_be_n (s_be[g])
      );

      assign s_dq_i[g] = (!s_ce[g] && !s_oe[g]) ? sram[s_addr[g][7:0]] : '0;

      always @(posedge clk) begin
        if (mem_init) begin
          for (int i = 0; i < 256; i++) sram[i] <= 32'hC0DE0000 | 32'(i);
        end else if (!s_ce[g] && !s_we[g] && !s_t[g]) begin
          for (int b = 0; b < 4; b++)
            if (!s_be[g][b]) sram[s_addr[g][7:0]][8*b +: 8] <= s_dq_o[g][8*b +: 8];
        end
      end
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    mem_op = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drives one request, follows it to its DONE cycle, then checks bus activity and the scoreboarded load word.
  task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [6:0] op, input logic [31:0] data, input logic from_done,
                        input int exp_stall, input logic [31:0] exp_ld,
                        input logic [31:0] exp_dq, input logic [3:0] exp_be);
    int          stalls = 0;
    int          we_low = 0;
    logic [31:0] dq_seen = '0;
    logic [3:0]  be_seen = '1;
    logic [17:0] addr_seen = '1;
    mem_op      = 1'b1;
    mem_wr      = wr;
    mem_addr    = addr;
    mem_op_type = op;
    st_data     = data;
    exp_q.push_back(exp_ld);
    if (from_done) @(negedge clk);
    #1;
    for (int c = 0; c < 64 && s_stall[sel]; c++) begin
      stalls++;
      if (!s_we[sel]) begin
        we_low++;
        dq_seen = s_dq_o[sel];
      end
      if (!s_ce[sel]) begin
        addr_seen = s_addr[sel];
        be_seen   = s_be[sel];
      end
      @(negedge clk);
      #1;
    end
    chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    chk({tag, " sram_addr"}, 32'(addr_seen), 32'(addr[19:2]));
    chk({tag, " be_n"}, 32'(be_seen), 32'(exp_be));
    if (wr) begin
      chk({tag, " we_n low cycles"}, 32'(we_low), 32'd1);
      chk({tag, " dq_o"}, dq_seen, exp_dq);
    end
    chk({tag, " ce_n in DONE"}, 32'(s_ce[sel]), 32'd1);
    chk({tag, " ld_data"}, s_ld[sel], exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b0;
    idle(5);
    #1;
    chk("idle ce_n", 32'(s_ce[0]), 32'd1);
    chk("idle oe_n", 32'(s_oe[0]), 32'd1);
    chk("idle we_n", 32'(s_we[0]), 32'd1);
    chk("idle be_n", 32'(s_be[0]), 32'hF);
    chk("idle dq_t", 32'(s_t[0]), 32'd1);
    chk("idle stall", 32'(s_stall[0]), 32'd0);
    chk("idle ld_data", s_ld[0], 32'd0);
    @(negedge clk);

    sel = 0;
    access("SW", 1'b1, 32'h10, MEM_OP_WORD, 32'hDEADBEEF, 1'b0, 4, 32'h0, 32'hDEADBEEF, 4'b0000);
    idle(2);
    access("LW1", 1'b0, 32'h10, MEM_OP_WORD, 32'h0, 1'b0, 2, 32'hDEADBEEF, 32'h0, 4'b0000);
    idle(2);
    access("SB", 1'b1, 32'h13, MEM_OP_BYTE, 32'h000000A5, 1'b0, 4, 32'hDEADBEEF, 32'hA5A5A5A5, 4'b0111);
    idle(2);
    access("LW2", 1'b0, 32'h10, MEM_OP_WORD, 32'h0, 1'b0, 2, 32'hA5ADBEEF, 32'h0, 4'b0000);
    idle(2);
    access("SH", 1'b1, 32'h22, MEM_OP_HWORD, 32'h00001234, 1'b0, 4, 32'hA5ADBEEF, 32'h12341234, 4'b0011);
    idle(2);
    access("LW3", 1'b0, 32'h20, MEM_OP_WORD, 32'h0, 1'b0, 2, 32'h12340008, 32'h0, 4'b0000);
    idle(2);
    access("SBU lo", 1'b1, 32'h48, MEM_OP_BYTEU, 32'hFFFFFF3C, 1'b0, 4, 32'h12340008, 32'h3C3C3C3C, 4'b1110);
    idle(2);
    access("SW odd code", 1'b1, 32'h4C, 7'h7F, 32'h01020304, 1'b0, 4, 32'h12340008, 32'h01020304, 4'b0000);
    idle(2);

    sel = 1;
    access("B2B LW a", 1'b0, 32'h40, MEM_OP_WORD, 32'h0, 1'b0, 4, 32'hC0DE0010, 32'h0, 4'b0000);
    access("B2B LW b", 1'b0, 32'h44, MEM_OP_WORD, 32'h0, 1'b1, 4, 32'hC0DE0011, 32'h0, 4'b0000);
    idle(3);
    #1;
    chk("B2B idle ce_n", 32'(s_ce[1]), 32'd1);
    @(negedge clk);

    sel = 0;
    mem_op = 1'b1; mem_wr = 1'b1; mem_addr = 32'h30; mem_op_type = MEM_OP_WORD; st_data = 32'h55;
    repeat (2) @(negedge clk);
    #1;
    chk("pulse we_n", 32'(s_we[0]), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst we_n", 32'(s_we[0]), 32'd1);
    chk("rst ce_n", 32'(s_ce[0]), 32'd1);
    chk("rst dq_t", 32'(s_t[0]), 32'd1);
    chk("rst stall", 32'(s_stall[0]), 32'd0);
    @(negedge clk);
    mem_op = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post rst stall", 32'(s_stall[0]), 32'd0);
    chk("post rst ce_n", 32'(s_ce[0]), 32'd1);
    chk("post rst ld_data", s_ld[0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_sram_ctrl.md
Name: dmem_sram_ctrl

Overview:
- Data-memory interface unit directly downstream of the pipeline's MEM stage.
- Consumes the MEM stage's address, access, write and op-type controls plus the raw store word.
- Drives the board's 32-bit asynchronous SRAM with byte lanes and returns the raw loaded word; the MEM stage performs load alignment and sign extension.
- Runs a multi-cycle access FSM and asserts stall to hold the pipeline until each access completes.

Parameters:
- ADDR_W, 18: SRAM word-address width.
- RD_WAIT, 1: read cycles with OE active before data capture; values below 1 are treated as 1.
- WR_WAIT, 1: cycles with WE low per write; values below 1 are treated as 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  in  32  byte address from MEM stage.
- mem_op  in  1  memory access requested this instruction.
- mem_wr  in  1  1=store, 0=load (valid when mem_op=1).
- mem_op_type  in  7  tMEM_OP_* code (NULL/WORD/HWORD/HWORDU/BYTE/BYTEU).
- st_data  in  32  unaligned store data (register rt value).
- ld_data  out  32  raw SRAM word from last completed read.
- stall  out  1  hold IF..MEM pipeline registers.
- sram_addr  out  ADDR_W  word address = mem_addr[ADDR_W+1:2].
- sram_dq_i  in  32  SRAM data bus input.
- sram_dq_o  out  32  SRAM data bus output.
- sram_dq_t  out  1  1=bus tristated (input), 0=drive sram_dq_o.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_be_n  out  4  byte-lane enables, active low; bit i = byte lane [8i+7:8i].

Behaviour:
- Reset (async, immediate): state IDLE, ce_n=1, oe_n=1, we_n=1, be_n=4'hF, dq_t=1, dq_o=0, sram_addr=0, ld_data=0. stall=0 while rst is high. Reset mid-access abandons the access with no completion.
- All SRAM outputs are registered. stall is combinational: stall = (IDLE & mem_op) | (state ∉ {IDLE, DONE}).
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE, mem_op=1, mem_wr=0:
  - Register sram_addr; ce_n=0, oe_n=0, be_n=0000.
  - Go to RD with the wait counter loaded to RD_WAIT-1.
- RD:
  - Counter decrements each cycle.
  - When the counter reaches 0, capture sram_dq_i into ld_data, deassert ce_n/oe_n (=1), and go to DONE.
  - Read latency: request cycle N; DONE at N+1+RD_WAIT.
- IDLE, mem_op=1, mem_wr=1:
  - Register sram_addr, aligned dq_o and be_n; ce_n=0, dq_t=0, we_n=1.
  - Go to WR_SETUP.
- WR_SETUP: one cycle, then to WR_PULSE with we_n=0 and the counter loaded to WR_WAIT-1.
- WR_PULSE: when the counter reaches 0, set we_n=1 and go to WR_HOLD.
- WR_HOLD: one cycle with data still driven. Then ce_n=1, dq_t=1, be_n=F, and go to DONE. Write DONE is at N+3+WR_WAIT.
- DONE:
  - One cycle with stall=0, so the pipeline advances at this edge.
  - MEM inputs still show the old request; they are ignored.
  - Unconditional transition to IDLE.
  - Back-to-back accesses therefore cost one IDLE request cycle each.
- IDLE with mem_op=0: no SRAM activity, stall=0.
- Store alignment:
  - WORD/NULL: dq_o=st_data, be_n=0000.
  - HWORD/HWORDU: dq_o={2{st_data[15:0]}}; be_n=0011 if addr[1]=1, else 1100.
  - BYTE/BYTEU: dq_o={4{st_data[7:0]}}; be_n clears only bit addr[1:0].
- Misaligned addresses: addr[1:0] bits below the access size are ignored. No exception is raised, and the access uses the containing word.
- Any other mem_op_type code: treated as WORD.
- ld_data holds its value until the next read completes; writes never modify it.

Decomposition:
- tMEM_OP_* codes and ALU/MEM widths stay in the shared MIPS1000_defines include.
- State encodings are local constants in this module.
- One combinational sub-module, dmem_st_align, computes (dq_o, be_n) from st_data, mem_addr[1:0] and mem_op_type.

Test Plan:
- Reset, then mem_op=0 for 5 cycles -> ce_n=oe_n=we_n=1, be_n=F, dq_t=1, stall=0, ld_data=0.
- SW addr 0x00000010, st_data 0xDEADBEEF; then LW same address with SRAM model -> sram_addr=4, be_n=0000.
  - Write: stall high for 4 cycles, we_n low exactly 1 cycle.
  - Read: stall high 2 cycles, ld_data=0xDEADBEEF in DONE.
- SB addr 0x13, st_data 0x000000A5 -> dq_o=0xA5A5A5A5, be_n=0111. A following LW returns 0xA5 in byte 3 with other bytes unchanged.
- SH addr 0x22, st_data 0x00001234 -> dq_o=0x12341234, be_n=0011.
- Back-to-back LW, LW with RD_WAIT=3 -> each read stalls 4 cycles, one DONE cycle between accesses, no duplicate access during DONE.
- Assert rst during WR_PULSE -> we_n, ce_n, dq_t go to 1 asynchronously, state returns to IDLE, stall=0.
